fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: PC_LIMIT, default 64'h0000000000000200; the first PC value that is never fetched (128 instructions x 4 bytes).
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 pc_in  in  64  current PC from the program counter.
REQ-005 pc_write  out  1  PC update enable to the program counter (PC advances or branches only when this is high).
REQ-006 pcsrc  in  1  branch taken or redirect; flushes fetch.
REQ-007 id_stall  in  1  decode stage cannot accept a new instruction.
REQ-008 imem_req  out  1  instruction memory read request, one-cycle pulse.
REQ-009 imem_addr  out  64  word-aligned read address.
REQ-010 imem_rvalid  in  1  read data valid, arriving one or more cycles after imem_req.
REQ-011 imem_rdata  in  32  instruction word.
REQ-012 if_id_valid  out  1  IF/ID register holds a live instruction.
REQ-013 if_id_pc  out  64  PC of the IF/ID instruction.
REQ-014 if_id_instr  out  32  instruction in IF/ID.
REQ-015 done  out  1  program end reached; sticky until reset.

Function
REQ-016 States SHALL be: REQ, WAIT, HOLD, DRAIN, DONE.
REQ-017 REQ state:
- If pc_in >= PC_LIMIT: go to DONE with no request.
- Otherwise: assert imem_req for one cycle with imem_addr = {pc_in[63:2], 2'b00}, latch pc_in into the request-PC register, and go to WAIT.
REQ-018 WAIT, imem_rvalid=1 with id_stall=0:
- Load if_id_pc (from the request-PC register) and if_id_instr (from imem_rdata).
- Set if_id_valid=1.
- Assert pc_write for that cycle.
- Go to REQ.
REQ-019 WAIT, imem_rvalid=1 with id_stall=1: capture the instruction and its PC into a hold register, then go to HOLD.
REQ-020 HOLD: remain while id_stall=1. When id_stall=0, load IF/ID from the hold register, set if_id_valid=1, assert pc_write, and go to REQ.
REQ-021 While id_stall=1, the IF/ID register and if_id_valid SHALL hold their values.
REQ-022 In any cycle with id_stall=0, pcsrc=0 and no IF/ID load, if_id_valid SHALL go to 0 (bubble).
REQ-023 pcsrc=1 has priority over id_stall and over imem_rvalid:
- Clear if_id_valid.
- Assert pc_write in the same cycle so the PC loads the branch target.
- Discard any captured or arriving instruction.
REQ-024 Next state on pcsrc=1:
- From WAIT with the response not yet arrived: go to DRAIN.
- From WAIT with imem_rvalid=1 in the same cycle: go to REQ.
- From REQ or HOLD: go to REQ.
- From DONE: go to REQ (a branch below PC_LIMIT restarts fetch).
REQ-025 DRAIN: ignore the next imem_rvalid pulse and its data, then go to REQ. pcsrc=1 while in DRAIN stays in DRAIN and asserts pc_write.
REQ-026 imem_rvalid outside WAIT and DRAIN SHALL be ignored.
REQ-027 pc_write is a Mealy output: high only in the cycles named in REQ-018, REQ-020, REQ-023 and REQ-025, low otherwise.
REQ-028 DONE: imem_req=0, pc_write=0, if_id_valid goes to 0 as in REQ-022, done=1.
REQ-029 At most one memory request is outstanding at any time.

Reset
REQ-030 On rst=1 at a clock edge:
- State=REQ; if_id_valid=0; if_id_pc=0; if_id_instr=32'h00000013 (NOP); done=0.
- Hold and request-PC registers cleared.
- imem_req=0 and pc_write=0 during the reset cycle.
REQ-031 Reset SHALL abort any operation in progress. A response to a request issued before reset, arriving after reset, SHALL be ignored because the state is then REQ.

Structure
REQ-032 The shared pipeline package SHALL hold:
- the NOP encoding 32'h00000013;
- the state enumeration;
- the IF/ID record type {valid, pc[63:0], instr[31:0]}.
REQ-033 One natural sub-module: if_id_reg (IF/ID register with load, hold and clear controls); the FSM stays in fetch_unit.

Verification
REQ-034 Reset, then pc_in=0; memory answers 0x00500093 after 1 cycle with id_stall=0 -> imem_req one cycle, addr=0; IF/ID={1, 0x0, 0x00500093}; one pc_write pulse.
REQ-035 pc_in=0x8; response arrives with id_stall=1 for 3 cycles -> state HOLD; pc_write=0 for those 3 cycles; IF/ID loads 0x8 in the cycle id_stall falls; no second request before that.
REQ-036 pc_in=0x10; pcsrc=1 one cycle after imem_req, response 2 cycles later -> pc_write in the pcsrc cycle; if_id_valid=0; late response discarded; next request uses the new pc_in (e.g. 0x40).
REQ-037 pc_in=0x1FC fetched, then pc_in=0x200 -> no imem_req; done=1; pc_write stays 0; pcsrc=1 with pc_in=0x20 restarts fetch at 0x20.
REQ-038 rst asserted while in WAIT, response arriving the cycle after reset -> IF/ID stays NOP/invalid; a fresh request is issued from the post-reset pc_in.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared pipeline definitions for the instruction fetch stage.
// Holds the NOP encoding, the fetch FSM state enumeration and the IF/ID record type.
package fetch_unit_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [2:0] {
    StReq,
    StWait,
    StHold,
    StDrain,
    StDone
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
  } if_id_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read bus between the fetch unit and instruction memory.
//   imem_req    : read request, one-cycle pulse (fetch -> memory)
//   imem_addr   : word-aligned read address     (fetch -> memory)
//   imem_rvalid : read data valid               (memory -> fetch)
//   imem_rdata  : instruction word              (memory -> fetch)
interface fetch_unit_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register (the if_id_reg sub-module of the fetch unit).
//   clk, rst   : clock, synchronous active-high reset
//   clear      : drop the live instruction (branch flush)
//   load       : capture load_pc/load_instr as a live instruction
//   hold       : decode stalled, keep current contents
//   load_pc    : PC to load
//   load_instr : instruction word to load
//   q          : registered IF/ID record
// Priority: rst > clear > load > hold > bubble.
module fetch_unit_if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic        hold,
  input  logic [63:0] load_pc,
  input  logic [31:0] load_instr,
  output if_id_t      q
);

  if_id_t q_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '{valid: 1'b0, pc: 64'h0, instr: NOP};
    end else if (clear) begin
      q_q.valid <= 1'b0;
    end else if (load) begin
      q_q <= '{valid: 1'b1, pc: load_pc, instr: load_instr};
    end else if (!hold) begin
      // Decode consumed the instruction and nothing new arrived: insert a bubble.
      q_q.valid <= 1'b0;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one instruction memory read at a time, steers the
// response into the IF/ID register (or a hold register while decode stalls), handles
// branch flushes and stops at PC_LIMIT.
//   clk, rst    : clock, synchronous active-high reset
//   pc_in       : current PC from the program counter
//   pc_write    : PC update enable (Mealy)
//   pcsrc       : branch taken / redirect, flushes fetch
//   id_stall    : decode cannot accept a new instruction
//   imem        : instruction memory bus (master side)
//   if_id_*     : IF/ID register contents
//   done        : program end reached, sticky until reset
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [63:0] PC_LIMIT = 64'h0000000000000200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [63:0]         pc_in,
  output logic                pc_write,
  input  logic                pcsrc,
  input  logic                id_stall,
  fetch_unit_if.master        imem,
  output logic                if_id_valid,
  output logic [63:0]         if_id_pc,
  output logic [31:0]         if_id_instr,
  output logic                done
);

  state_e      state_q, state_d;
  logic [63:0] req_pc_q;
  logic [63:0] hold_pc_q;
  logic [31:0] hold_instr_q;
  logic        done_q;

  logic        at_limit;
  logic        load;
  logic        capture;
  logic [63:0] load_pc;
  logic [31:0] load_instr;
  if_id_t      if_id;

  assign at_limit       = (pc_in >= PC_LIMIT);
  assign imem.imem_addr = {pc_in[63:2], 2'b00};

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    imem.imem_req = 1'b0;
    load          = 1'b0;
    capture       = 1'b0;
    load_pc       = req_pc_q;
    load_instr    = imem.imem_rdata;
    if (!rst) begin
      if (pcsrc) begin
        pc_write = 1'b1;
        case (state_q)
          StWait:  state_d = imem.imem_rvalid ? StReq : StDrain;
          // A response landing together with the redirect completes the drain.
          StDrain: state_d = imem.imem_rvalid ? StReq : StDrain;
          default: state_d = StReq;
        endcase
      end else begin
        unique case (state_q)
          StReq: begin
            if (at_limit) begin
              state_d = StDone;
            end else begin
              imem.imem_req = 1'b1;
              state_d       = StWait;
            end
          end
          StWait: begin
            if (imem.imem_rvalid) begin
              if (id_stall) begin
                capture = 1'b1;
                state_d = StHold;
              end else begin
                load     = 1'b1;
                pc_write = 1'b1;
                state_d  = StReq;
              end
            end
          end
          StHold: begin
            if (!id_stall) begin
              load       = 1'b1;
              load_pc    = hold_pc_q;
              load_instr = hold_instr_q;
              pc_write   = 1'b1;
              state_d    = StReq;
            end
          end
          StDrain: begin
            if (imem.imem_rvalid) state_d = StReq;
          end
          StDone: state_d = StDone;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StReq;
      req_pc_q     <= 64'h0;
      hold_pc_q    <= 64'h0;
      hold_instr_q <= 32'h0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (imem.imem_req) req_pc_q <= pc_in;
      if (capture) begin
        hold_pc_q    <= req_pc_q;
        hold_instr_q <= imem.imem_rdata;
      end
      if (state_d == StDone) done_q <= 1'b1;
    end
  end

  fetch_unit_if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .clear      (pcsrc),
    .load       (load),
    .hold       (id_stall),
    .load_pc    (load_pc),
    .load_instr (load_instr),
    .q          (if_id)
  );

  assign if_id_valid = if_id.valid;
  assign if_id_pc    = if_id.pc;
  assign if_id_instr = if_id.instr;
  assign done        = done_q;

endmodule
